// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// instruction field constants, datapath mux codes and exception causes.
package ctrl_pkg;

    typedef enum logic [5:0] {
        RST = 6'd0, SP_INIT, FETCH, F_WAIT, IR_LOAD, DECODE,
        EXEC_R, WB_R, EXEC_I, WB_I,
        ADDR, MEM_RD, M_WAIT, LD_MDR, WB_LD, MEM_WR,
        BR, JMP, JR,
        MD_START, MD_WAIT, MD_DONE,
        EXC_EPC, EXC_RD, X_WAIT, EXC_MDR, EXC_JMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;

    localparam logic [2:0] PC_ALU    = 3'd0;
    localparam logic [2:0] PC_ALUOUT = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_VEC    = 3'd3;
    localparam logic [2:0] PC_REGA   = 3'd4;

    localparam logic [2:0] IORD_PC     = 3'd0;
    localparam logic [2:0] IORD_ALUOUT = 3'd1;
    localparam logic [2:0] IORD_VEC    = 3'd2;

    localparam logic [1:0] CAUSE_BADOP = 2'd0;
    localparam logic [1:0] CAUSE_OVF   = 2'd1;
    localparam logic [1:0] CAUSE_DIVZ  = 2'd2;
    localparam logic [1:0] CAUSE_MDTO  = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_SP = 2'd3;

    localparam logic [3:0] M2R_ALU = 4'd0;
    localparam logic [3:0] M2R_MDR = 4'd1;
    localparam logic [3:0] M2R_SP  = 4'd7;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    // Stack pointer reset value and exception vector base (vector = base + cause).
    localparam logic [31:0] SP_INIT_ADDR = 32'h7fff_fffc;
    localparam logic [7:0]  VEC_BASE     = 8'd253;

    function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Loadable down-counter with zero flag; shared between memory wait states
// and the mult/div watchdog.
module ctrl_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle MIPS control FSM with configurable memory latency and mult/div
// handshake. Define MD_WATCHDOG_EN to trap mult/div units that never finish.
module control_unit_mc
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 1,
    parameter int CNT_W      = 4,
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       md_done,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       eq_or_ne,
    output logic [2:0] pc_src,
    output logic [2:0] iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       rega_load,
    output logic       regb_load,
    output logic       aluout_write,
    output logic       mdr_load,
    output logic       epc_write,
    output logic       hilo_write,
    output logic [1:0] reg_dst,
    output logic [3:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       md_start,
    output logic       md_sel,
    output logic [1:0] exc_cause,
    output logic [5:0] state_dbg
);

    // Counter is widened if needed so the watchdog timeout always fits.
    localparam int TO_W = $clog2(MD_TIMEOUT + 1);
    localparam int CW   = (CNT_W > TO_W) ? CNT_W : TO_W;
    localparam logic [CW-1:0] MEM_LOAD = (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : '0;
`ifdef MD_WATCHDOG_EN
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_TIMEOUT);
`endif

    state_t        state, next_state;
    logic [1:0]    cause_nxt;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;

    ctrl_wait_counter #(.W(CW)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        next_state = state;
        cause_nxt  = CAUSE_BADOP;
        case (state)
            RST:     next_state = SP_INIT;
            SP_INIT: next_state = FETCH;
            FETCH:   next_state = (MEM_WAIT == 0) ? IR_LOAD : F_WAIT;
            F_WAIT:  if (cnt_zero) next_state = IR_LOAD;
            IR_LOAD: next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND: next_state = EXEC_R;
                            FN_JR:                  next_state = JR;
                            FN_MULT:                next_state = MD_START;
                            FN_DIV: begin
                                // A zero divisor traps before the unit is ever started.
                                if (div_zero) begin
                                    next_state = EXC_EPC;
                                    cause_nxt  = CAUSE_DIVZ;
                                end else begin
                                    next_state = MD_START;
                                end
                            end
                            default: next_state = EXC_EPC;
                        endcase
                    end
                    OP_ADDI, OP_ADDIU: next_state = EXEC_I;
                    OP_LW, OP_SW:      next_state = ADDR;
                    OP_BEQ, OP_BNE:    next_state = BR;
                    OP_J:              next_state = JMP;
                    default:           next_state = EXC_EPC;
                endcase
            end
            EXEC_R: begin
                if (overflow && funct != FN_AND) begin
                    next_state = EXC_EPC;
                    cause_nxt  = CAUSE_OVF;
                end else begin
                    next_state = WB_R;
                end
            end
            EXEC_I: begin
                if (overflow && opcode == OP_ADDI) begin
                    next_state = EXC_EPC;
                    cause_nxt  = CAUSE_OVF;
                end else begin
                    next_state = WB_I;
                end
            end
            ADDR:     next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   next_state = (MEM_WAIT == 0) ? LD_MDR : M_WAIT;
            M_WAIT:   if (cnt_zero) next_state = LD_MDR;
            LD_MDR:   next_state = WB_LD;
            MD_START: next_state = MD_WAIT;
            MD_WAIT: begin
                if (md_done) begin
                    next_state = MD_DONE;
                end
`ifdef MD_WATCHDOG_EN
                else if (cnt_zero) begin
                    next_state = EXC_EPC;
                    cause_nxt  = CAUSE_MDTO;
                end
`endif
            end
            EXC_EPC: next_state = EXC_RD;
            EXC_RD:  next_state = (MEM_WAIT == 0) ? EXC_MDR : X_WAIT;
            X_WAIT:  if (cnt_zero) next_state = EXC_MDR;
            EXC_MDR: next_state = EXC_JMP;
            WB_R, WB_I, WB_LD, MEM_WR, BR, JMP, JR, MD_DONE, EXC_JMP:
                     next_state = FETCH;
            default: next_state = RST;
        endcase
    end

    // Each memory access arms the counter on its way into the wait state.
    always_comb begin
        cnt_load = (state == FETCH) || (state == MEM_RD) || (state == EXC_RD);
        cnt_val  = MEM_LOAD;
        cnt_dec  = (state inside {F_WAIT, M_WAIT, X_WAIT});
`ifdef MD_WATCHDOG_EN
        if (next_state == MD_START) begin
            cnt_load = 1'b1;
            cnt_val  = MD_LOAD;
        end
        if (state inside {MD_START, MD_WAIT})
            cnt_dec = 1'b1;
`endif
    end

    // Outputs are decoded from next_state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RST;
            pc_write      <= 1'b0;
            pc_write_cond <= 1'b0;
            eq_or_ne      <= 1'b0;
            pc_src        <= '0;
            iord          <= '0;
            mem_wr        <= 1'b0;
            ir_write      <= 1'b0;
            reg_write     <= 1'b0;
            rega_load     <= 1'b0;
            regb_load     <= 1'b0;
            aluout_write  <= 1'b0;
            mdr_load      <= 1'b0;
            epc_write     <= 1'b0;
            hilo_write    <= 1'b0;
            reg_dst       <= '0;
            mem_to_reg    <= '0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= '0;
            alu_op        <= '0;
            md_start      <= 1'b0;
            md_sel        <= 1'b0;
            exc_cause     <= '0;
        end else begin
            state         <= next_state;
            pc_write      <= 1'b0;
            pc_write_cond <= 1'b0;
            mem_wr        <= 1'b0;
            ir_write      <= 1'b0;
            reg_write     <= 1'b0;
            rega_load     <= 1'b0;
            regb_load     <= 1'b0;
            aluout_write  <= 1'b0;
            mdr_load      <= 1'b0;
            epc_write     <= 1'b0;
            hilo_write    <= 1'b0;
            md_start      <= 1'b0;
            case (next_state)
                SP_INIT: begin
                    reg_dst    <= DST_SP;
                    mem_to_reg <= M2R_SP;
                    reg_write  <= 1'b1;
                end
                FETCH: begin
                    iord      <= IORD_PC;
                    alu_src_a <= 1'b0;
                    alu_src_b <= SRCB_FOUR;
                    alu_op    <= ALU_ADD;
                    pc_src    <= PC_ALU;
                    pc_write  <= 1'b1;
                end
                IR_LOAD: ir_write <= 1'b1;
                DECODE: begin
                    rega_load    <= 1'b1;
                    regb_load    <= 1'b1;
                    alu_src_a    <= 1'b0;
                    alu_src_b    <= SRCB_IMMSH;
                    alu_op       <= ALU_ADD;
                    aluout_write <= 1'b1;
                end
                EXEC_R: begin
                    alu_src_a    <= 1'b1;
                    alu_src_b    <= SRCB_REGB;
                    alu_op       <= alu_for_funct(funct);
                    aluout_write <= 1'b1;
                end
                EXEC_I, ADDR: begin
                    alu_src_a    <= 1'b1;
                    alu_src_b    <= SRCB_IMM;
                    alu_op       <= ALU_ADD;
                    aluout_write <= 1'b1;
                end
                WB_R: begin
                    reg_dst    <= DST_RD;
                    mem_to_reg <= M2R_ALU;
                    reg_write  <= 1'b1;
                end
                WB_I: begin
                    reg_dst    <= DST_RT;
                    mem_to_reg <= M2R_ALU;
                    reg_write  <= 1'b1;
                end
                MEM_RD: iord <= IORD_ALUOUT;
                LD_MDR: mdr_load <= 1'b1;
                WB_LD: begin
                    reg_dst    <= DST_RT;
                    mem_to_reg <= M2R_MDR;
                    reg_write  <= 1'b1;
                end
                MEM_WR: begin
                    iord   <= IORD_ALUOUT;
                    mem_wr <= 1'b1;
                end
                BR: begin
                    alu_src_a     <= 1'b1;
                    alu_src_b     <= SRCB_REGB;
                    alu_op        <= ALU_SUB;
                    pc_src        <= PC_ALUOUT;
                    pc_write_cond <= 1'b1;
                    eq_or_ne      <= (opcode == OP_BNE);
                end
                JMP: begin
                    pc_src   <= PC_JUMP;
                    pc_write <= 1'b1;
                end
                JR: begin
                    pc_src   <= PC_REGA;
                    pc_write <= 1'b1;
                end
                MD_START: begin
                    md_start <= 1'b1;
                    md_sel   <= (funct == FN_DIV);
                end
                MD_DONE: hilo_write <= 1'b1;
                EXC_EPC: begin
                    alu_src_a <= 1'b0;
                    alu_src_b <= SRCB_FOUR;
                    alu_op    <= ALU_SUB;
                    epc_write <= 1'b1;
                    exc_cause <= cause_nxt;
                end
                EXC_RD:  iord <= IORD_VEC;
                EXC_MDR: mdr_load <= 1'b1;
                EXC_JMP: begin
                    pc_src   <= PC_VEC;
                    pc_write <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc with MEM_WAIT=3 and MD_TIMEOUT=5;
// watchdog steps follow MD_WATCHDOG_EN.
module tb_control_unit_mc;
    import ctrl_pkg::*;

    localparam int MW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       overflow, div_zero, md_done;
    logic       pc_write, pc_write_cond, eq_or_ne;
    logic [2:0] pc_src, iord;
    logic       mem_wr, ir_write, reg_write, rega_load, regb_load;
    logic       aluout_write, mdr_load, epc_write, hilo_write;
    logic [1:0] reg_dst;
    logic [3:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       md_start, md_sel;
    logic [1:0] exc_cause;
    logic [5:0] state_dbg;
    logic [39:0] allOut;

    int checks = 0;
    int errors = 0;
    int mdStartCount = 0;
    int base;

    control_unit_mc #(.MEM_WAIT(MW), .CNT_W(4), .MD_TIMEOUT(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .div_zero(div_zero), .md_done(md_done),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .eq_or_ne(eq_or_ne),
        .pc_src(pc_src), .iord(iord), .mem_wr(mem_wr), .ir_write(ir_write),
        .reg_write(reg_write), .rega_load(rega_load), .regb_load(regb_load),
        .aluout_write(aluout_write), .mdr_load(mdr_load), .epc_write(epc_write),
        .hilo_write(hilo_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .md_start(md_start), .md_sel(md_sel), .exc_cause(exc_cause),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign allOut = {pc_write, pc_write_cond, eq_or_ne, pc_src, iord, mem_wr, ir_write,
                     reg_write, rega_load, regb_load, aluout_write, mdr_load, epc_write,
                     hilo_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     md_start, md_sel, exc_cause, state_dbg};

    always @(negedge clk) if (md_start) mdStartCount++;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From a FETCH cycle, present the instruction and walk it to DECODE.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        repeat (MW) stepCycle();
        stepCycle();
        checkOutput("ir_load", 64'({ir_write, state_dbg}), 64'({1'b1, 6'(IR_LOAD)}));
        stepCycle();
    endtask

    // From EXC_EPC, follow the vectored exception back to FETCH.
    task automatic finishException(input logic [1:0] cause);
        checkOutput("exc_epc", 64'({epc_write, exc_cause}), 64'({1'b1, cause}));
        stepCycle();
        checkOutput("exc_rd", 64'({iord, epc_write}), 64'({3'd2, 1'b0}));
        repeat (MW) stepCycle();
        stepCycle();
        checkOutput("exc_mdr", 64'(mdr_load), 64'(1'b1));
        stepCycle();
        checkOutput("exc_jmp", 64'({pc_write, pc_src}), 64'({1'b1, 3'd3}));
        stepCycle();
        checkOutput("exc_ret", 64'(state_dbg), 64'(6'(FETCH)));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; opcode = '0; funct = '0;
        overflow = 1'b0; div_zero = 1'b0; md_done = 1'b0;
        repeat (2) stepCycle();
        checkOutput("reset_zero", 64'(allOut), 64'(0));
        reset = 1'b1;
        stepCycle();
        checkOutput("sp_init", 64'({reg_write, reg_dst, mem_to_reg, state_dbg}),
                    64'({1'b1, 2'd3, 4'd7, 6'(SP_INIT)}));
        stepCycle();
        checkOutput("fetch", 64'({reg_write, pc_write, iord, alu_src_a, alu_src_b, alu_op, pc_src, state_dbg}),
                    64'({1'b0, 1'b1, 3'd0, 1'b0, 2'd1, 3'd1, 3'd0, 6'(FETCH)}));

        // add with 3 fetch wait cycles
        opcode = OP_RTYPE; funct = FN_ADD;
        for (int i = 0; i < MW; i++) begin
            stepCycle();
            checkOutput("f_wait", 64'({ir_write, pc_write}), 64'(0));
        end
        stepCycle();
        checkOutput("add_ir_load", 64'(ir_write), 64'(1'b1));
        stepCycle();
        checkOutput("decode", 64'({rega_load, regb_load, aluout_write, alu_src_a, alu_src_b, alu_op}),
                    64'({1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 3'd1}));
        stepCycle();
        checkOutput("exec_r_add", 64'({alu_src_a, alu_src_b, alu_op, aluout_write}),
                    64'({1'b1, 2'd0, 3'd1, 1'b1}));
        stepCycle();
        checkOutput("wb_r", 64'({reg_dst, mem_to_reg, reg_write, epc_write}),
                    64'({2'd1, 4'd0, 1'b1, 1'b0}));
        stepCycle();
        checkOutput("add_ret", 64'(state_dbg), 64'(6'(FETCH)));

        // and ignores overflow
        applyStimulus(OP_RTYPE, FN_AND);
        stepCycle();
        overflow = 1'b1;
        checkOutput("exec_r_and", 64'(alu_op), 64'(3'd3));
        stepCycle();
        overflow = 1'b0;
        checkOutput("and_no_trap", 64'({state_dbg, epc_write}), 64'({6'(WB_R), 1'b0}));
        stepCycle();

        // addi overflow traps with cause 1
        applyStimulus(OP_ADDI, 6'h00);
        stepCycle();
        checkOutput("exec_i", 64'({alu_src_a, alu_src_b, alu_op}), 64'({1'b1, 2'd2, 3'd1}));
        overflow = 1'b1;
        stepCycle();
        overflow = 1'b0;
        checkOutput("epc_alu", 64'({alu_src_a, alu_src_b, alu_op}), 64'({1'b0, 2'd1, 3'd2}));
        finishException(2'd1);

        // addiu never traps
        applyStimulus(OP_ADDIU, 6'h00);
        stepCycle();
        overflow = 1'b1;
        stepCycle();
        overflow = 1'b0;
        checkOutput("wb_i", 64'({reg_dst, reg_write, mem_to_reg, epc_write}),
                    64'({2'd0, 1'b1, 4'd0, 1'b0}));
        stepCycle();

        // lw with memory wait
        applyStimulus(OP_LW, 6'h00);
        stepCycle();
        checkOutput("addr", 64'({alu_src_b, aluout_write}), 64'({2'd2, 1'b1}));
        stepCycle();
        checkOutput("mem_rd", 64'({iord, mem_wr}), 64'({3'd1, 1'b0}));
        for (int i = 0; i < MW; i++) begin
            stepCycle();
            checkOutput("m_wait", 64'(mdr_load), 64'(1'b0));
        end
        stepCycle();
        checkOutput("ld_mdr", 64'(mdr_load), 64'(1'b1));
        stepCycle();
        checkOutput("wb_ld", 64'({mem_to_reg, reg_dst, reg_write}), 64'({4'd1, 2'd0, 1'b1}));
        stepCycle();

        // sw
        applyStimulus(OP_SW, 6'h00);
        stepCycle();
        stepCycle();
        checkOutput("mem_wr", 64'({iord, mem_wr}), 64'({3'd1, 1'b1}));
        stepCycle();
        checkOutput("sw_ret", 64'({mem_wr, state_dbg}), 64'({1'b0, 6'(FETCH)}));

        // bne, beq, j, jr
        applyStimulus(OP_BNE, 6'h00);
        stepCycle();
        checkOutput("bne", 64'({pc_write_cond, pc_write, pc_src, eq_or_ne, alu_op}),
                    64'({1'b1, 1'b0, 3'd1, 1'b1, 3'd2}));
        stepCycle();
        applyStimulus(OP_BEQ, 6'h00);
        stepCycle();
        checkOutput("beq", 64'({pc_write_cond, eq_or_ne}), 64'({1'b1, 1'b0}));
        stepCycle();
        applyStimulus(OP_J, 6'h00);
        stepCycle();
        checkOutput("j", 64'({pc_write, pc_src}), 64'({1'b1, 3'd2}));
        stepCycle();
        applyStimulus(OP_RTYPE, FN_JR);
        stepCycle();
        checkOutput("jr", 64'({pc_write, pc_src}), 64'({1'b1, 3'd4}));
        stepCycle();

        // unknown opcode
        applyStimulus(6'h3f, 6'h00);
        stepCycle();
        finishException(2'd0);

        // div by zero never starts the unit
        base = mdStartCount;
        div_zero = 1'b1;
        applyStimulus(OP_RTYPE, FN_DIV);
        stepCycle();
        finishException(2'd2);
        div_zero = 1'b0;
        checkOutput("divz_no_start", 64'(mdStartCount - base), 64'(0));

        // mult, md_done 7 cycles after md_start
        base = mdStartCount;
        applyStimulus(OP_RTYPE, FN_MULT);
        stepCycle();
        checkOutput("mult_start", 64'({md_start, md_sel, state_dbg}), 64'({1'b1, 1'b0, 6'(MD_START)}));
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkOutput("md_wait", 64'({md_start, hilo_write}), 64'(0));
        end
        stepCycle();
        md_done = 1'b1;
        stepCycle();
        md_done = 1'b0;
        checkOutput("md_done", 64'({hilo_write, state_dbg}), 64'({1'b1, 6'(MD_DONE)}));
        stepCycle();
        checkOutput("mult_ret", 64'({hilo_write, pc_write}), 64'({1'b0, 1'b1}));
        checkOutput("mult_one_start", 64'(mdStartCount - base), 64'(1));

`ifdef MD_WATCHDOG_EN
        applyStimulus(OP_RTYPE, FN_DIV);
        stepCycle();
        checkOutput("div_start", 64'({md_start, md_sel}), 64'({1'b1, 1'b1}));
        repeat (5) stepCycle();
        checkOutput("wd_last_wait", 64'(state_dbg), 64'(6'(MD_WAIT)));
        stepCycle();
        finishException(2'd3);
        applyStimulus(OP_RTYPE, FN_DIV);
        stepCycle();
        repeat (5) stepCycle();
        md_done = 1'b1;
        stepCycle();
        md_done = 1'b0;
        checkOutput("wd_done_wins", 64'({hilo_write, epc_write}), 64'({1'b1, 1'b0}));
        stepCycle();
`else
        applyStimulus(OP_RTYPE, FN_DIV);
        stepCycle();
        checkOutput("div_start", 64'({md_start, md_sel}), 64'({1'b1, 1'b1}));
        repeat (12) stepCycle();
        checkOutput("no_wd_wait", 64'({state_dbg, epc_write}), 64'({6'(MD_WAIT), 1'b0}));
        md_done = 1'b1;
        stepCycle();
        md_done = 1'b0;
        checkOutput("div_done", 64'(hilo_write), 64'(1'b1));
        stepCycle();
`endif

        // reset in the middle of MD_WAIT
        applyStimulus(OP_RTYPE, FN_MULT);
        repeat (3) stepCycle();
        base = mdStartCount;
        reset = 1'b0;
        #1;
        checkOutput("midreset_zero", 64'(allOut), 64'(0));
        stepCycle();
        checkOutput("midreset_hold", 64'(allOut), 64'(0));
        reset = 1'b1;
        stepCycle();
        checkOutput("re_sp_init", 64'({reg_write, state_dbg}), 64'({1'b1, 6'(SP_INIT)}));
        stepCycle();
        checkOutput("re_fetch", 64'({reg_write, pc_write, state_dbg}), 64'({1'b0, 1'b1, 6'(FETCH)}));
        repeat (2) stepCycle();
        checkOutput("no_restart", 64'(mdStartCount - base), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Parametrised successor to the multicycle MIPS control FSM.
- Configurable memory read latency instead of fixed wait states.
- Widened instruction set: R-type add/sub/and, addi/addiu, lw/sw, beq/bne, j, jr, mult/div.
- mult/div use a start/done handshake to the external multiplier/divider; exceptions are vectored by cause.
- Sits between the IR decode fields and the datapath muxes and register enables.

Parameters:
- MEM_WAIT, 1: memory read latency in cycles after address presentation; legal range 0..7.
- CNT_W, 4: width of the shared wait/watchdog counter.
- MD_TIMEOUT, 40: maximum cycles in MD_WAIT before a timeout exception. Only meaningful with the optional feature compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- overflow  in  1  ALU overflow (combinational)
- div_zero  in  1  divisor == 0 (combinational)
- md_done  in  1  mult/div unit finished (one-cycle pulse)
- pc_write, pc_write_cond, eq_or_ne  out  1  PC enables; branch sense (1 = bne)
- pc_src  out  3  0 ALU, 1 ALUOut, 2 jump target, 3 MDR vector, 4 regA
- iord  out  3  0 PC, 1 ALUOut, 2 exception vector
- mem_wr, ir_write, reg_write, rega_load, regb_load, aluout_write, mdr_load, epc_write, hilo_write  out  1  enables
- reg_dst  out  2  0 rt, 1 rd, 3 $sp
- mem_to_reg  out  4  0 ALUOut, 1 MDR, 7 SP init constant
- alu_src_a  out  1  0 PC, 1 regA
- alu_src_b  out  2  0 regB, 1 const 4, 2 signext imm, 3 imm<<2
- alu_op  out  3  1 add, 2 sub, 3 and
- md_start  out  1  mult/div start pulse
- md_sel  out  1  0 mult, 1 div
- exc_cause  out  2  0 bad opcode, 1 overflow, 2 div by zero, 3 md timeout
- state_dbg  out  6  current state encoding

Behaviour:
Outputs and reset:
- All outputs are registered and decoded from next_state, so each is valid during the cycle the FSM occupies its state.
- Enables not listed for a state are 0; mux selects hold their previous value.
- While reset is low: state = RST and every output is 0, asynchronously.

Fetch and decode:
- RST → SP_INIT: reg_dst=3, mem_to_reg=7, reg_write=1 for one cycle. Then FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=1, alu_op=1, pc_src=0, pc_write=1 (one cycle).
  - If MEM_WAIT=0 → IR_LOAD.
  - Otherwise the counter loads MEM_WAIT-1 and the FSM goes to F_WAIT.
- F_WAIT: stays until the counter reaches 0, decrementing each cycle. Exactly MEM_WAIT cycles elapse between FETCH and IR_LOAD.
- IR_LOAD: ir_write=1.
- DECODE: rega_load=1, regb_load=1, alu_src_a=0, alu_src_b=3, alu_op=1, aluout_write=1 (branch target). Dispatch on opcode/funct. Unknown encodings → EXC with cause 0.

Execute paths:
- R-type: EXEC_R with alu_src_a=1, alu_src_b=0, alu_op from funct, aluout_write=1.
  - add/sub with overflow=1 in that cycle → EXC cause 1.
  - Otherwise WB_R: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- addi/addiu: EXEC_I with alu_src_b=2. Overflow traps for addi only. WB_I uses reg_dst=0.
- lw/sw: ADDR (alu_src_b=2, aluout_write=1).
  - lw: MEM_RD (iord=1), wait MEM_WAIT cycles, LD_MDR (mdr_load=1), WB_LD (mem_to_reg=1, reg_dst=0, reg_write=1).
  - sw: MEM_WR with iord=1, mem_wr=1 for one cycle.
- beq/bne: BR with alu_op=2, pc_write_cond=1, pc_src=1, eq_or_ne per opcode. Always followed by FETCH.
- j: pc_src=2, pc_write=1.
- jr: pc_src=4, pc_write=1.
- mult/div:
  - MD_START: md_start=1 for one cycle, md_sel set.
  - div with div_zero=1 → EXC cause 2, and md_start is suppressed.
  - MD_WAIT: md_sel holds. md_done is sampled only in this state.
  - MD_DONE: hilo_write=1, then FETCH.

Exceptions:
- EXC_EPC: alu_src_a=0, alu_src_b=1, alu_op=2, epc_write=1, exc_cause latched.
- EXC_RD: iord=2, vector byte address = 253 + exc_cause; then wait MEM_WAIT cycles.
- EXC_MDR: mdr_load=1.
- EXC_JMP: pc_src=3, pc_write=1, then FETCH.

Edge cases:
- Reset mid-operation aborts any state immediately; a pending mult/div is abandoned and md_start is never re-pulsed.
- MEM_WAIT=0 skips every wait state.

Optional Feature:
- Macro: MD_WATCHDOG_EN.
- Defined: the counter loads MD_TIMEOUT on MD_START. If it reaches 0 in MD_WAIT without md_done → EXC cause 3. md_done arriving on the expiry cycle wins.
- Undefined: MD_WAIT waits indefinitely and cause 3 is never produced.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding
  - opcode/funct constants (incl. add 0x20, and 0x24, div 0x1a, mult 0x18, jr 0x08, addi 0x08, addiu 0x09)
  - alu_op, pc_src, iord and exc_cause codes
  - SP_INIT and vector-base constants
- Sub-module ctrl_wait_counter: loadable down-counter with a zero flag, shared by memory waits and the watchdog.

Test Plan:
- Reset low mid-MD_WAIT, then high → all outputs 0 during reset; SP_INIT reg_write=1 for exactly one cycle; FETCH follows.
- MEM_WAIT=3, add $3=$1+$2 without overflow → FETCH to IR_LOAD spans 4 cycles; WB_R has reg_dst=1, reg_write=1; no epc_write.
- addi with overflow=1 in EXEC_I → EXC_EPC epc_write=1 and exc_cause=1; EXC_RD iord=2; pc_write with pc_src=3 three cycles plus MEM_WAIT later.
- div with div_zero=1 → md_start never asserted; exc_cause=2.
- mult with md_done 7 cycles after md_start → hilo_write=1 exactly one cycle after md_done, then FETCH.
- MD_WATCHDOG_EN, MD_TIMEOUT=5, md_done never arrives → exc_cause=3 after 5 MD_WAIT cycles. Repeat with md_done on cycle 5 → normal completion.
